// File: rtl/uart_cmd_ctrl.sv
// UART command frame controller: assembles HEADER/ADDR/DATA/CSUM frames
// from the byte receiver and issues one register write per valid frame.
module uart_cmd_ctrl #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             rx_overrun,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        ISSUE = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [7:0]    addr_reg;
    logic [7:0]    data_reg;
    logic [7:0]    csum;
    logic          expired;

    // Expected checksum and inter-byte timeout detection
    assign csum    = 8'(addr_reg + data_reg);
    assign expired = (timer == TW'(TIMEOUT_CYC - 1));

    // Frame FSM with registered write request, pulses and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_valid   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
            err_cnt    <= '0;
            busy       <= 1'b0;
        end else begin
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (rx_done && (rx_data == HEADER)) begin
                        state <= ADDR;
                        busy  <= 1'b1;
                    end
                end
                ADDR, DATA, CSUM: begin
                    if (rx_done) begin
                        // A byte on the expiry cycle still counts as in time
                        timer <= '0;
                        if (state == ADDR) begin
                            addr_reg <= rx_data;
                            state    <= DATA;
                        end else if (state == DATA) begin
                            data_reg <= rx_data;
                            state    <= CSUM;
                        end else if (rx_data == csum) begin
                            wr_addr  <= addr_reg;
                            wr_data  <= data_reg;
                            wr_valid <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        end
                    end else if (expired) begin
                        timer     <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    // Completion pulse takes priority so pulses stay exclusive;
                    // a byte landing on the accept cycle is dropped quietly
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        frame_ok <= 1'b1;
                    end else if (rx_done) begin
                        rx_overrun <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    wr_valid <= 1'b0;
                    timer    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl (TIMEOUT_CYC = 1000).
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       frame_ok;
    logic       frame_err;
    logic       rx_overrun;
    logic [7:0] err_cnt;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int n_ok  = 0;
    int n_err = 0;
    int n_ovr = 0;
    int n_excl = 0;

    uart_cmd_ctrl #(
        .HEADER(8'hA5),
        .TIMEOUT_CYC(1000),
        .ERR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .rx_overrun(rx_overrun),
        .err_cnt(err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle
    always @(negedge clk) begin
        if (frame_ok)   n_ok++;
        if (frame_err)  n_err++;
        if (rx_overrun) n_ovr++;
        if (32'(frame_ok) + 32'(frame_err) + 32'(rx_overrun) > 1) n_excl++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int e0;
        int o0;
        int r0;
        int unstable;
        int missed;

        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; wr_ready = 1'b1;
        tick(); tick();
        chk("rst_wr_valid", 32'(wr_valid), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_pulses", 32'({frame_ok, frame_err, rx_overrun}), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Valid frame with wr_ready high
        o0 = n_ok;
        send(8'hA5);
        chk("v1_busy", 32'(busy), 1);
        send(8'h10); send(8'h3C);
        chk("v1_no_valid_early", 32'(wr_valid), 0);
        send(8'h4C);
        chk("v1_wr_valid", 32'(wr_valid), 1);
        chk("v1_wr_addr", 32'(wr_addr), 32'h10);
        chk("v1_wr_data", 32'(wr_data), 32'h3C);
        tick();
        chk("v1_valid_drop", 32'(wr_valid), 0);
        chk("v1_frame_ok", 32'(frame_ok), 1);
        chk("v1_busy_idle", 32'(busy), 0);
        tick();
        chk("v1_ok_once", 32'(n_ok - o0), 1);
        chk("v1_err_cnt", 32'(err_cnt), 0);

        // Bad checksum, then a good frame
        e0 = n_err;
        send(8'hA5); send(8'h10); send(8'h3C); send(8'h00);
        chk("bc_no_valid", 32'(wr_valid), 0);
        chk("bc_frame_err", 32'(frame_err), 1);
        chk("bc_err_cnt", 32'(err_cnt), 1);
        tick();
        chk("bc_err_once", 32'(n_err - e0), 1);
        send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
        chk("bc2_wr_valid", 32'(wr_valid), 1);
        chk("bc2_wr_addr", 32'(wr_addr), 32'h01);
        chk("bc2_wr_data", 32'(wr_data), 32'h02);
        tick();
        chk("bc2_frame_ok", 32'(frame_ok), 1);

        // Timeout: 0x10 accepted, last tolerated cycle is 1000 cycles later
        e0 = n_err;
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 999; i++) tick();
        chk("to_no_err_yet", 32'(n_err - e0), 0);
        chk("to_busy_before", 32'(busy), 1);
        tick();
        chk("to_frame_err", 32'(frame_err), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_err_cnt", 32'(err_cnt), 2);
        tick();

        // Byte on the expiry cycle keeps the frame alive
        e0 = n_err;
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 999; i++) tick();
        send(8'h3C);
        chk("tx_no_err", 32'(frame_err), 0);
        chk("tx_busy", 32'(busy), 1);
        send(8'h4C);
        chk("tx_wr_valid", 32'(wr_valid), 1);
        tick();
        chk("tx_frame_ok", 32'(frame_ok), 1);
        chk("tx_err_total", 32'(n_err - e0), 0);
        chk("tx_err_cnt", 32'(err_cnt), 2);

        // Backpressure with an overrun byte
        wr_ready = 1'b0;
        r0 = n_ovr;
        unstable = 0;
        send(8'hA5); send(8'h20); send(8'h01); send(8'h21);
        for (int i = 0; i < 20; i++) begin
            if (!(wr_valid === 1'b1 && wr_addr === 8'h20 && wr_data === 8'h01)) unstable++;
            tick();
        end
        send(8'h55);
        chk("bp_overrun", 32'(rx_overrun), 1);
        chk("bp_addr_hold", 32'(wr_addr), 32'h20);
        chk("bp_data_hold", 32'(wr_data), 32'h01);
        for (int i = 0; i < 29; i++) begin
            if (!(wr_valid === 1'b1 && wr_addr === 8'h20 && wr_data === 8'h01)) unstable++;
            tick();
        end
        chk("bp_stable", 32'(unstable), 0);
        chk("bp_overrun_once", 32'(n_ovr - r0), 1);
        wr_ready = 1'b1;
        tick();
        chk("bp_done_valid", 32'(wr_valid), 0);
        chk("bp_frame_ok", 32'(frame_ok), 1);

        // Reset mid-frame, noise in IDLE, then a normal frame
        e0 = n_err;
        send(8'hA5); send(8'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_err_cnt", 32'(err_cnt), 0);
        chk("mr_outputs", 32'({wr_valid, frame_ok, frame_err, rx_overrun}), 0);
        send(8'h00); send(8'hFF);
        chk("mr_noise_idle", 32'(busy), 0);
        send(8'hA5); send(8'h10); send(8'h3C); send(8'h4C);
        chk("mr_wr_addr", 32'(wr_addr), 32'h10);
        chk("mr_wr_data", 32'(wr_data), 32'h3C);
        tick();
        chk("mr_frame_ok", 32'(frame_ok), 1);
        chk("mr_no_err", 32'(n_err - e0), 0);

        // Error counter saturation
        missed = 0;
        for (int i = 0; i < 300; i++) begin
            send(8'hA5); send(8'h10); send(8'h3C); send(8'h00);
            if (frame_err !== 1'b1) missed++;
            if (i == 254) chk("sat_reach", 32'(err_cnt), 255);
        end
        chk("sat_all_pulsed", 32'(missed), 0);
        chk("sat_hold", 32'(err_cnt), 255);
        tick();
        chk("sat_exclusive", 32'(n_excl), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
